rob_queue: RTL

- Circular reorder buffer and in-order commit sequencer for the out-of-order core.
- Dispatch allocates entries at the tail. CDB writeback marks entries complete. The head entry is presented to the commit stage as rob_valid/rob_ready/commit_opcode.
- The commit stage answers with rob_pop, and this block retires the head on that signal.
- Sits between rename/dispatch, the CDB, and commit.

---
 rtl/rob_queue_pkg.sv | 19 +
 rtl/rob_queue_if.sv | 42 ++++
 rtl/rob_queue_ptr.sv | 53 +++++
 rtl/rob_queue.sv | 108 ++++++++++
 4 files changed

// File: rtl/rob_queue_pkg.sv
// Shared types and constants for the ROB slice.
// Optional build macro used by rob_queue: ROB_CDB_BYPASS_EN.
package rob_queue_pkg;

  localparam int unsigned ROB_DEPTH  = 16;
  localparam int unsigned ROB_PREG_W = 6;

  localparam logic [6:0] STORE_OPCODE = 7'b0100011;
  localparam logic [6:0] BR_OPCODE    = 7'b1100011;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic [6:0]            opcode;
    logic [4:0]            rd_arch;
    logic [ROB_PREG_W-1:0] rd_phys;
  } rob_entry_t;

endpackage

// File: rtl/rob_queue_if.sv
// Dispatch / CDB / commit signal bundle for rob_queue.
// The master side is dispatch+CDB+commit; the slave side is the ROB.
interface rob_queue_if
  import rob_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = ROB_DEPTH,
  parameter int unsigned PREG_W = ROB_PREG_W
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic              flush;
  logic              enq_valid;
  logic              enq_ready;
  logic [6:0]        enq_opcode;
  logic [4:0]        enq_rd_arch;
  logic [PREG_W-1:0] enq_rd_phys;
  logic [IDX_W-1:0]  enq_rob_idx;
  logic              cdb_valid;
  logic [IDX_W-1:0]  cdb_rob_idx;
  logic              rob_valid;
  logic              rob_ready;
  logic [6:0]        commit_opcode;
  logic [4:0]        commit_rd_arch;
  logic [PREG_W-1:0] commit_rd_phys;
  logic              rob_pop;
  logic [IDX_W:0]    occupancy;

  modport master (
    output flush, enq_valid, enq_opcode, enq_rd_arch, enq_rd_phys,
           cdb_valid, cdb_rob_idx, rob_pop,
    input  enq_ready, enq_rob_idx, rob_valid, rob_ready,
           commit_opcode, commit_rd_arch, commit_rd_phys, occupancy
  );

  modport slave (
    input  flush, enq_valid, enq_opcode, enq_rd_arch, enq_rd_phys,
           cdb_valid, cdb_rob_idx, rob_pop,
    output enq_ready, enq_rob_idx, rob_valid, rob_ready,
           commit_opcode, commit_rd_arch, commit_rd_phys, occupancy
  );

endinterface

// File: rtl/rob_queue_ptr.sv
// Wrap-bit head/tail pointer pair for the ROB: full, empty, occupancy.
module rob_ptr #(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             tail_inc_i,
  input  logic             head_inc_i,
  output logic [IDX_W-1:0] head_idx_o,
  output logic [IDX_W-1:0] tail_idx_o,
  output logic [IDX_W:0]   occupancy_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

  logic [IDX_W:0] head_q, head_d;
  logic [IDX_W:0] tail_q, tail_d;

  // Next pointer values: flush rewinds both, otherwise advance on handshakes.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (head_inc_i) head_d = head_q + PTR_ONE;
      if (tail_inc_i) tail_d = tail_q + PTR_ONE;
    end
  end

  // Pointer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign head_idx_o  = head_q[IDX_W-1:0];
  assign tail_idx_o  = tail_q[IDX_W-1:0];
  assign empty_o     = (head_q == tail_q);
  assign full_o      = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
                       (head_q[IDX_W] != tail_q[IDX_W]);
  assign occupancy_o = tail_q - head_q;

endmodule

// File: rtl/rob_queue.sv
// Circular reorder buffer with in-order commit.
// Build macro: ROB_CDB_BYPASS_EN lets a CDB write to the head make it
// committable in the same cycle.
module rob_queue
  import rob_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = ROB_DEPTH,
  parameter int unsigned PREG_W = ROB_PREG_W
) (
  input  logic         clk,
  input  logic         rst_n,
  rob_queue_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [6:0]        opcode;
    logic [4:0]        rd_arch;
    logic [PREG_W-1:0] rd_phys;
  } entry_t;

  entry_t entries_q [DEPTH];
  entry_t entries_d [DEPTH];

  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             full, empty;
  logic             head_ready;
  logic             enq_fire, pop_fire, cdb_hit;

  rob_ptr #(
    .IDX_W (IDX_W)
  ) u_ptr (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (bus.flush),
    .tail_inc_i  (enq_fire),
    .head_inc_i  (pop_fire),
    .head_idx_o  (head_idx),
    .tail_idx_o  (tail_idx),
    .occupancy_o (bus.occupancy),
    .full_o      (full),
    .empty_o     (empty)
  );

`ifdef ROB_CDB_BYPASS_EN
  assign head_ready = entries_q[head_idx].done ||
                      (bus.cdb_valid && (bus.cdb_rob_idx == head_idx) &&
                       entries_q[head_idx].valid);
`else
  assign head_ready = entries_q[head_idx].done;
`endif

  assign enq_fire = bus.enq_valid && !full;
  assign pop_fire = bus.rob_pop && !empty && head_ready;
  assign cdb_hit  = bus.cdb_valid && entries_q[bus.cdb_rob_idx].valid;

  assign bus.enq_ready      = !full;
  assign bus.enq_rob_idx    = tail_idx;
  assign bus.rob_valid      = !empty;
  assign bus.rob_ready      = head_ready;
  assign bus.commit_opcode  = entries_q[head_idx].opcode;
  assign bus.commit_rd_arch = entries_q[head_idx].rd_arch;
  assign bus.commit_rd_phys = entries_q[head_idx].rd_phys;

  // Entry updates; pop is applied last so it overrides a CDB hit on the head.
  always_comb begin
    entries_d = entries_q;
    if (enq_fire) begin
      entries_d[tail_idx].valid   = 1'b1;
      entries_d[tail_idx].done    = 1'b0;
      entries_d[tail_idx].opcode  = bus.enq_opcode;
      entries_d[tail_idx].rd_arch = bus.enq_rd_arch;
      entries_d[tail_idx].rd_phys = bus.enq_rd_phys;
    end
    if (cdb_hit) begin
      entries_d[bus.cdb_rob_idx].done = 1'b1;
    end
    if (pop_fire) begin
      entries_d[head_idx].valid = 1'b0;
      entries_d[head_idx].done  = 1'b0;
    end
  end

  // Entry storage; reset and flush clear every field so reads are never X.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      entries_q <= entries_d;
    end
  end

  a_cdb_valid_entry : assert property (
    @(posedge clk) disable iff (!rst_n || bus.flush)
    bus.cdb_valid |-> entries_q[bus.cdb_rob_idx].valid
  );

  a_pop_legal : assert property (
    @(posedge clk) disable iff (!rst_n || bus.flush)
    bus.rob_pop |-> (!empty && head_ready)
  );

endmodule
